// File: rtl/seven_segment_scan_decoder.sv
// Decodes a multiplexed active-low seven-segment scan back into a 16-bit hex word.
// value publishes two cycles after the capture that completes a qualifying frame; no backpressure.
module seven_segment_scan_decoder #(
   parameter int SETTLE_CYCLES = 4,
   parameter int STABLE_FRAMES = 2,
   parameter int IDLE_TIMEOUT  = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        AN1,
   input  logic        AN2,
   input  logic        AN3,
   input  logic        AN4,
   input  logic        CA,
   input  logic        CB,
   input  logic        CC,
   input  logic        CD,
   input  logic        CE,
   input  logic        CF,
   input  logic        CG,
   input  logic        DP,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        frame_done,
   output logic        glyph_error
);

   localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [7:0]        SETTLE_N = 8'(SETTLE_CYCLES);
   localparam logic [3:0]        STABLE_N = 4'(STABLE_FRAMES);
   localparam logic [IDLE_W-1:0] IDLE_N   = IDLE_W'(IDLE_TIMEOUT);

   // Pin vector: [3:0] anodes (bit 0 = AN1), [10:4] segments a..g (a at bit 10), [11] DP
   logic [11:0] pins_raw;
   logic [11:0] sync_meta_q, sync_meta_d;
   logic [11:0] sync_q, sync_d;

   logic [1:0]  prev_idx_q, prev_idx_d;
   logic [6:0]  prev_seg_q, prev_seg_d;
   logic        prev_vld_q, prev_vld_d;
   logic [7:0]  settle_q, settle_d;
   logic        armed_q, armed_d;

   logic [15:0] slot_q, slot_d;
   logic [3:0]  bad_q, bad_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] frame_word_q, frame_word_d;
   logic        frame_bad_q, frame_bad_d;
   logic        frame_done_q, frame_done_d;
   logic        glyph_error_q, glyph_error_d;

   logic [15:0] cand_q, cand_d;
   logic [3:0]  match_q, match_d;
   logic [15:0] value_q, value_d;
   logic        value_valid_q, value_valid_d;
   logic [IDLE_W-1:0] idle_q, idle_d;

   logic [3:0]  an_low;
   logic [6:0]  seg_lit;
   logic [1:0]  idx;
   logic        idx_vld;
   logic        same, new_act, arm_eff, capture, complete, timeout, legal;
   logic [3:0]  nib;
   logic [3:0]  sel;
   logic        dp_unused;

   assign pins_raw  = {DP, CA, CB, CC, CD, CE, CF, CG, AN4, AN3, AN2, AN1};
   assign dp_unused = sync_q[11];

   always_comb begin
      sync_meta_d = pins_raw;
      sync_d      = sync_meta_q;
      an_low      = ~sync_q[3:0];
      seg_lit     = ~sync_q[10:4];

      idx     = 2'd0;
      idx_vld = 1'b1;
      case (an_low)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx_vld = 1'b0;
      endcase

      // Lit pattern {a,b,c,d,e,f,g} back to a hex nibble
      legal = 1'b1;
      nib   = 4'h0;
      case (seg_lit)
         7'h7E: nib = 4'h0;
         7'h30: nib = 4'h1;
         7'h6D: nib = 4'h2;
         7'h79: nib = 4'h3;
         7'h33: nib = 4'h4;
         7'h5B: nib = 4'h5;
         7'h5F: nib = 4'h6;
         7'h70: nib = 4'h7;
         7'h7F: nib = 4'h8;
         7'h7B: nib = 4'h9;
         7'h77: nib = 4'hA;
         7'h1F: nib = 4'hB;
         7'h4E: nib = 4'hC;
         7'h3D: nib = 4'hD;
         7'h4F: nib = 4'hE;
         7'h47: nib = 4'hF;
         default: legal = 1'b0;
      endcase

      same    = idx_vld && prev_vld_q && (idx == prev_idx_q) && (seg_lit == prev_seg_q);
      new_act = idx_vld && !(prev_vld_q && (idx == prev_idx_q));
      if (!idx_vld)
         settle_d = 8'd0;
      else if (same)
         settle_d = (settle_q == 8'hFF) ? settle_q : settle_q + 8'd1;
      else
         settle_d = 8'd1;

      // One capture per anode activation; a new index re-arms in the same cycle
      arm_eff = armed_q || new_act;
      capture = idx_vld && arm_eff && (settle_d == SETTLE_N);
      armed_d = !idx_vld ? 1'b1 : (capture ? 1'b0 : arm_eff);

      prev_vld_d = idx_vld;
      prev_idx_d = idx;
      prev_seg_d = seg_lit;

      sel          = 4'b0001 << idx;
      slot_d       = slot_q;
      bad_d        = bad_q;
      mask_d       = mask_q;
      frame_word_d = frame_word_q;
      frame_bad_d  = frame_bad_q;
      if (capture) begin
         slot_d[{idx, 2'b00} +: 4] = nib;
         bad_d[idx]                = !legal;
         mask_d                    = mask_q | sel;
      end
      complete = capture && (mask_d == 4'hF);
      if (complete) begin
         frame_word_d = slot_d;
         frame_bad_d  = |bad_d;
         mask_d       = 4'h0;
         bad_d        = 4'h0;
      end
      frame_done_d  = complete;
      glyph_error_d = capture && !legal;

      cand_d        = cand_q;
      match_d       = match_q;
      value_d       = value_q;
      value_valid_d = value_valid_q;
      if (frame_done_q) begin
         if (frame_bad_q) begin
            match_d = 4'd0;
         end else if (frame_word_q == cand_q) begin
            match_d = (match_q >= STABLE_N) ? STABLE_N : match_q + 4'd1;
         end else begin
            cand_d  = frame_word_q;
            match_d = 4'd1;
         end
         if (!frame_bad_q && (match_d == STABLE_N)) begin
            value_d       = cand_d;
            value_valid_d = 1'b1;
         end
      end

      // Counter saturates at the timeout so the idle condition persists until the next capture
      timeout = !capture && (idle_q >= IDLE_N - IDLE_W'(1));
      if (capture)
         idle_d = '0;
      else if (timeout)
         idle_d = IDLE_N;
      else
         idle_d = idle_q + IDLE_W'(1);
      if (timeout) begin
         value_valid_d = 1'b0;
         mask_d        = 4'h0;
         bad_d         = 4'h0;
         match_d       = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta_q   <= 12'hFFF;
         sync_q        <= 12'hFFF;
         prev_idx_q    <= 2'd0;
         prev_seg_q    <= 7'd0;
         prev_vld_q    <= 1'b0;
         settle_q      <= 8'd0;
         armed_q       <= 1'b1;
         slot_q        <= 16'h0;
         bad_q         <= 4'h0;
         mask_q        <= 4'h0;
         frame_word_q  <= 16'h0;
         frame_bad_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         glyph_error_q <= 1'b0;
         cand_q        <= 16'h0;
         match_q       <= 4'd0;
         value_q       <= 16'h0;
         value_valid_q <= 1'b0;
         idle_q        <= '0;
      end else begin
         sync_meta_q   <= sync_meta_d;
         sync_q        <= sync_d;
         prev_idx_q    <= prev_idx_d;
         prev_seg_q    <= prev_seg_d;
         prev_vld_q    <= prev_vld_d;
         settle_q      <= settle_d;
         armed_q       <= armed_d;
         slot_q        <= slot_d;
         bad_q         <= bad_d;
         mask_q        <= mask_d;
         frame_word_q  <= frame_word_d;
         frame_bad_q   <= frame_bad_d;
         frame_done_q  <= frame_done_d;
         glyph_error_q <= glyph_error_d;
         cand_q        <= cand_d;
         match_q       <= match_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         idle_q        <= idle_d;
      end
   end

   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign frame_done  = frame_done_q;
   assign glyph_error = glyph_error_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Scoreboard bench for seven_segment_scan_decoder: frame-level reference model feeds an expectation queue.
module tb_seven_segment_scan_decoder;

   localparam int SETTLE = 4;
   localparam int STABLE = 2;
   localparam int IDLE   = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  an = 4'hF;
   logic [6:0]  seg_n = 7'h7F;
   logic        dp = 1'b1;
   logic [15:0] value;
   logic        value_valid;
   logic        frame_done;
   logic        glyph_error;

   always #5 clk = ~clk;

   seven_segment_scan_decoder #(
      .SETTLE_CYCLES(SETTLE),
      .STABLE_FRAMES(STABLE),
      .IDLE_TIMEOUT (IDLE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .AN1        (an[0]),
      .AN2        (an[1]),
      .AN3        (an[2]),
      .AN4        (an[3]),
      .CA         (seg_n[6]),
      .CB         (seg_n[5]),
      .CC         (seg_n[4]),
      .CD         (seg_n[3]),
      .CE         (seg_n[2]),
      .CF         (seg_n[1]),
      .CG         (seg_n[0]),
      .DP         (dp),
      .value      (value),
      .value_valid(value_valid),
      .frame_done (frame_done),
      .glyph_error(glyph_error)
   );

   typedef struct packed {
      logic [15:0] val;
      logic        vld;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   fd_count = 0;
   int   ge_count = 0;
   logic pend     = 1'b0;

   logic [15:0] m_cand  = 16'h0;
   int          m_match = 0;
   logic [15:0] m_val   = 16'h0;
   logic        m_vld   = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1111110;
         4'h1: return 7'b0110000;
         4'h2: return 7'b1101101;
         4'h3: return 7'b1111001;
         4'h4: return 7'b0110011;
         4'h5: return 7'b1011011;
         4'h6: return 7'b1011111;
         4'h7: return 7'b1110000;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1111011;
         4'hA: return 7'b1110111;
         4'hB: return 7'b0011111;
         4'hC: return 7'b1001110;
         4'hD: return 7'b0111101;
         4'hE: return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   task automatic model_frame(input logic [15:0] w, input logic bad);
      if (bad) begin
         m_match = 0;
      end else if (w == m_cand) begin
         if (m_match < STABLE) m_match++;
      end else begin
         m_cand  = w;
         m_match = 1;
      end
      if (!bad && m_match == STABLE) begin
         m_val = m_cand;
         m_vld = 1'b1;
      end
      exp_q.push_back('{val: m_val, vld: m_vld});
   endtask

   task automatic drive(input int idx, input logic [6:0] lit, input int dwell);
      an      = 4'hF;
      an[idx] = 1'b0;
      seg_n   = ~lit;
      repeat (dwell) @(negedge clk);
   endtask

   task automatic scan(input logic [15:0] word, input bit rev, input int bad_digit);
      model_frame(word, bad_digit >= 0);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = rev ? 3 - k : k;
         drive(idx, (idx == bad_digit) ? 7'h00 : glyph(word[idx*4 +: 4]), 8);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("value", 32'(value), 32'(e.val));
               chk("value_valid", 32'(value_valid), 32'(e.vld));
            end
            pend = 1'b0;
         end
         if (frame_done) begin
            fd_count++;
            pend = 1'b1;
         end
         if (glyph_error) ge_count++;
      end
   end

   initial begin
      int f0;
      int g0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_value", 32'(value), 0);
      chk("rst_value_valid", 32'(value_valid), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_glyph_error", 32'(glyph_error), 0);

      // 0x1234, four frames in scan order
      f0 = fd_count;
      repeat (4) scan(16'h1234, 1'b0, -1);
      repeat (4) @(negedge clk);
      chk("frames_1234", fd_count - f0, 4);

      // Steady 0xBEEF, mixed frame, then 0xC0DE
      repeat (2) scan(16'hBEEF, 1'b0, -1);
      model_frame(16'hC0EF, 1'b0);
      drive(0, glyph(4'hF), 8);
      drive(1, glyph(4'hE), 8);
      drive(2, glyph(4'h0), 8);
      drive(3, glyph(4'hC), 8);
      repeat (2) scan(16'hC0DE, 1'b0, -1);

      // Blank digit 2 discards the frame and restarts the match count
      g0 = ge_count;
      scan(16'h5678, 1'b0, -1);
      scan(16'h5678, 1'b0, 2);
      scan(16'h5678, 1'b0, -1);
      scan(16'h5678, 1'b0, -1);
      chk("glyph_errors", ge_count - g0, 1);

      // Dwell too short plus two-anode overlap: nothing captured, idle timeout
      f0 = fd_count;
      g0 = ge_count;
      repeat (3) begin
         for (int k = 0; k < 4; k++) begin
            drive(k, glyph(4'(k + 3)), 3);
            an = 4'b1100;
            @(negedge clk);
         end
      end
      chk("valid_before_idle", 32'(value_valid), 1);
      an = 4'hF;
      repeat (80) @(negedge clk);
      chk("valid_after_idle", 32'(value_valid), 0);
      chk("value_after_idle", 32'(value), 32'h5678);
      chk("frames_short_dwell", fd_count - f0, 0);
      chk("glyphs_short_dwell", ge_count - g0, 0);
      m_vld   = 1'b0;
      m_match = 0;

      // Reset after two digits; reverse scan exposes any stale slot mask
      drive(0, glyph(4'h9), 8);
      drive(1, glyph(4'h9), 8);
      reset = 1'b1;
      an    = 4'hF;
      repeat (3) @(negedge clk);
      chk("mid_rst_value", 32'(value), 0);
      chk("mid_rst_value_valid", 32'(value_valid), 0);
      chk("mid_rst_frame_done", 32'(frame_done), 0);
      chk("mid_rst_glyph_error", 32'(glyph_error), 0);
      reset   = 1'b0;
      m_cand  = 16'h0;
      m_match = 0;
      m_val   = 16'h0;
      m_vld   = 1'b0;
      f0 = fd_count;
      repeat (2) scan(16'h00A5, 1'b1, -1);
      repeat (4) @(negedge clk);
      chk("frames_00a5", fd_count - f0, 2);

      // AN4 -> AN1 order still maps by anode
      repeat (3) scan(16'hF00D, 1'b1, -1);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
